// File: rtl/mfp_button_event_controller.sv
// rtl/mfp_button_event_controller.sv - button press/release/long-press detector with round-robin event FIFO
module mfp_button_event_controller #(
  parameter int WIDTH       = 5,
  parameter int LONG_CYCLES = 50000000,
  parameter int FIFO_AW     = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   btn_in,
  input  logic               enable,
  input  logic               ev_pop,
  output logic               ev_valid,
  output logic [7:0]         ev_data,
  output logic [FIFO_AW:0]   ev_count,
  output logic               irq,
  output logic               overflow,
  input  logic               clr_overflow
);

  localparam int CW    = $clog2(LONG_CYCLES + 1);
  localparam int PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);

  typedef enum logic {IDLE, GRANT} arb_state_t;

  arb_state_t         state;
  logic               primed;
  logic [WIDTH-1:0]   prev;
  logic [WIDTH-1:0]   press_pend, long_pend, rel_pend, any_pend;
  logic [WIDTH-1:0]   press_set, long_set, rel_set;
  logic [WIDTH-1:0]   press_clr, long_clr, rel_clr, gnt_mask;
  logic [WIDTH-1:0]   press_nxt, long_nxt, rel_nxt;
  logic [CW-1:0]      hold_cnt [WIDTH];
  logic [PW-1:0]      rr_ptr, gnt_idx;
  logic               gnt_found;
  logic [1:0]         gnt_type;
  logic               lost, full, do_push, do_pop;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;

  always_comb begin
    press_set = (primed && enable) ? (~prev & btn_in) : '0;
    rel_set   = (primed && enable) ? (prev & ~btn_in) : '0;
    for (int i = 0; i < WIDTH; i++)
      long_set[i] = btn_in[i] && enable && (hold_cnt[i] == LONG_MAX - 1'b1);
    any_pend = press_pend | long_pend | rel_pend;
    lost = |((press_set & press_pend) | (long_set & long_pend) | (rel_set & rel_pend));
  end

  // Round-robin search starting at rr_ptr, wrapping modulo WIDTH.
  always_comb begin
    int k;
    k         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int j = 0; j < WIDTH; j++) begin
      k = int'(rr_ptr) + j;
      if (k >= WIDTH) k = k - WIDTH;
      if (!gnt_found && any_pend[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(k);
      end
    end
    gnt_mask          = '0;
    gnt_mask[gnt_idx] = gnt_found;
    gnt_type = press_pend[gnt_idx] ? 2'b01 : (long_pend[gnt_idx] ? 2'b11 : 2'b10);
    full     = (count == (FIFO_AW+1)'(DEPTH));
    do_push  = (state == GRANT) && gnt_found && (!full || ev_pop);
    do_pop   = ev_pop && (count != '0);
    press_clr = (do_push && gnt_type == 2'b01) ? gnt_mask : '0;
    long_clr  = (do_push && gnt_type == 2'b11) ? gnt_mask : '0;
    rel_clr   = (do_push && gnt_type == 2'b10) ? gnt_mask : '0;
    // Set wins over a same-cycle clear from the push.
    press_nxt = (press_pend & ~press_clr) | press_set;
    long_nxt  = (long_pend & ~long_clr) | long_set;
    rel_nxt   = (rel_pend & ~rel_clr) | rel_set;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev       <= '0;
      primed     <= 1'b0;
      press_pend <= '0;
      long_pend  <= '0;
      rel_pend   <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) hold_cnt[i] <= '0;
    end else begin
      prev       <= btn_in;
      primed     <= 1'b1;
      press_pend <= press_nxt;
      long_pend  <= long_nxt;
      rel_pend   <= rel_nxt;
      if (lost)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (btn_in[i] && enable) begin
          if (hold_cnt[i] != LONG_MAX) hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end else begin
          hold_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= (|(press_nxt | long_nxt | rel_nxt)) ? GRANT : IDLE;
      if (do_push)
        rr_ptr <= (gnt_idx == PW'(WIDTH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      irq    <= 1'b0;
    end else begin
      irq <= ev_valid;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {gnt_type, 6'(gnt_idx)};
  end

  assign ev_valid = (count != '0);
  assign ev_data  = ev_valid ? mem[rd_ptr] : 8'h00;
  assign ev_count = count;

endmodule

// File: tb/tb_mfp_button_event_controller.sv
// tb/tb_mfp_button_event_controller.sv - directed and randomized checks against an event-queue reference model
module tb_mfp_button_event_controller;

  localparam int W = 5;
  localparam int LC = 10;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic [W-1:0] btn_in = '0;
  logic         enable = 1'b1;
  logic         ev_pop = 1'b0;
  logic         clr_overflow = 1'b0;
  logic         ev_valid;
  logic [7:0]   ev_data;
  logic [AW:0]  ev_count;
  logic         irq;
  logic         overflow;

  int tests = 0;
  int fails = 0;

  mfp_button_event_controller #(.WIDTH(W), .LONG_CYCLES(LC), .FIFO_AW(AW)) dut (
    .clk(clk), .resetn(resetn), .btn_in(btn_in), .enable(enable), .ev_pop(ev_pop),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_count(ev_count), .irq(irq),
    .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: pending requests as per-button flags, FIFO as a queue.
  bit [W-1:0]  m_prev, m_press, m_long, m_rel;
  bit          m_primed, m_irq, m_ovf;
  int          m_hold [W];
  int          m_rr;
  byte unsigned m_q [$];
  byte unsigned drained [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = '0; m_press = '0; m_long = '0; m_rel = '0;
    m_primed = 0; m_irq = 0; m_ovf = 0; m_rr = 0;
    for (int i = 0; i < W; i++) m_hold[i] = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit [W-1:0] sp, sl, sr;
    int g;
    int b;
    bit [1:0] gt;
    bit lost;
    if (!resetn) begin
      model_reset();
      return;
    end
    sp = '0; sl = '0; sr = '0; g = -1; gt = 0;
    for (int i = 0; i < W; i++) begin
      if (m_primed && enable) begin
        sp[i] = !m_prev[i] && btn_in[i];
        sr[i] = m_prev[i] && !btn_in[i];
      end
      sl[i] = btn_in[i] && enable && (m_hold[i] == LC - 1);
    end
    lost = |((sp & m_press) | (sl & m_long) | (sr & m_rel));
    m_irq = (m_q.size() > 0);
    for (int j = 0; j < W; j++) begin
      b = (m_rr + j) % W;
      if (g < 0 && (m_press[b] || m_long[b] || m_rel[b])) g = b;
    end
    if (ev_pop && m_q.size() > 0) begin
      if (g >= 0 || 1) void'(m_q.pop_front());
    end
    if (g >= 0 && (m_q.size() < DEPTH)) begin
      if (m_press[g]) begin gt = 2'b01; m_press[g] = 0; end
      else if (m_long[g]) begin gt = 2'b11; m_long[g] = 0; end
      else begin gt = 2'b10; m_rel[g] = 0; end
      m_q.push_back({gt, 6'(g)});
      m_rr = (g + 1) % W;
    end
    m_press |= sp; m_long |= sl; m_rel |= sr;
    if (lost) m_ovf = 1;
    else if (clr_overflow) m_ovf = 0;
    for (int i = 0; i < W; i++)
      m_hold[i] = (btn_in[i] && enable) ? ((m_hold[i] < LC) ? m_hold[i] + 1 : LC) : 0;
    m_prev = btn_in;
    m_primed = 1;
  endtask

  task automatic compare_all();
    check("ev_valid", ev_valid, m_q.size() > 0);
    check("ev_count", ev_count, m_q.size());
    check("ev_data", ev_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
    check("irq", irq, m_irq);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic drain();
    drained.delete();
    ev_pop = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!ev_valid) break;
      drained.push_back(ev_data);
      ev_pop = 1'b1;
      tick();
      ev_pop = 1'b0;
    end
    check("drain_empty", ev_valid, 0);
  endtask

  initial begin
    int n40;
    #2;
    // Held through reset: no press; release gives exactly one 0x82.
    btn_in = 5'b00100;
    do_reset();
    check("rst_count", ev_count, 0);
    repeat (3) tick();
    check("t1_no_press", ev_count, 0);
    btn_in = 5'b00000;
    tick();
    check("t1_edge_k", ev_valid, 0);
    tick();
    check("t1_valid", ev_valid, 1);
    check("t1_data", ev_data, 8'h82);
    tick();
    check("t1_irq", irq, 1);
    drain();
    check("t1_one_event", drained.size(), 1);

    // Simultaneous presses with RR pointer at 0.
    do_reset();
    btn_in = 5'b01001;
    tick();
    tick();
    check("t2_head0", ev_data, 8'h40);
    tick();
    check("t2_count", ev_count, 2);
    check("t2_head1", ev_data, 8'h40);
    check("t2_irq", irq, 1);
    ev_pop = 1'b1; tick(); ev_pop = 1'b0;
    check("t2_second", ev_data, 8'h43);
    btn_in = 5'b00000;
    repeat (2) tick();
    drain();

    // Long press.
    do_reset();
    btn_in = 5'b00010;
    repeat (25) tick();
    btn_in = 5'b00000;
    repeat (3) tick();
    check("t3_count", ev_count, 3);
    drain();
    check("t3_n", drained.size(), 3);
    if (drained.size() == 3) begin
      check("t3_e0", drained[0], 8'h41);
      check("t3_e1", drained[1], 8'hC1);
      check("t3_e2", drained[2], 8'h81);
    end

    // FIFO saturation, then pops release the backlog.
    do_reset();
    btn_in = 5'b11111;
    repeat (6) tick();
    btn_in = 5'b11110;
    tick();
    check("t4_sat", ev_count, 4);
    ev_pop = 1'b1; tick(); tick(); ev_pop = 1'b0;
    tick();
    check("t4_refill", ev_count, 4);
    check("t4_head", ev_data, 8'h42);
    check("t4_ovf", overflow, 0);

    // Blocked pending bit hit twice -> overflow, only one press queued.
    btn_in = 5'b01110; tick();
    btn_in = 5'b01111; tick();
    btn_in = 5'b01110; tick();
    btn_in = 5'b01111; tick();
    check("t5_ovf_set", overflow, 1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    check("t5_ovf_clr", overflow, 0);
    drain();
    n40 = 0;
    foreach (drained[i]) if (drained[i] == 8'h40) n40++;
    check("t5_one_press", n40, 1);

    // Detection disabled: only the pre-existing pending event drains.
    btn_in = 5'b00000;
    do_reset();
    btn_in = 5'b00100;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      btn_in = 5'($urandom_range(0, 31));
      tick();
    end
    btn_in = 5'b00010;
    repeat (15) tick();
    check("t6_count", ev_count, 1);
    check("t6_data", ev_data, 8'h42);
    enable = 1'b1;
    tick();
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 7) == 0) btn_in = btn_in ^ 5'(1 << $urandom_range(0, W - 1));
      ev_pop = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 19) != 0);
      clr_overflow = ($urandom_range(0, 19) == 0);
      tick();
    end
    ev_pop = 1'b0; clr_overflow = 1'b0; enable = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
